// File: rtl/event_sched_pkg.sv
// Shared definitions for the two-input event scheduler: value width derivation,
// the {value, addr} event record and the arbiter state encoding.
package event_sched_pkg;

  localparam int DATA_WIDTH_DEF = 14;
  localparam int ADDR_W         = 16;

  // Event values carry four guard bits above the filter pixel width.
  function automatic int calc_vw(input int dw);
    return dw + 4;
  endfunction

  localparam int VW_DEF = calc_vw(DATA_WIDTH_DEF);

  // The top and the FIFOs store events as {value, addr}, matching this layout.
  typedef struct packed {
    logic [VW_DEF-1:0] value;
    logic [ADDR_W-1:0] addr;
  } event_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/event_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on data_o while not empty,
// so the output slot can load it in the cycle right after the push.
module event_fifo #(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/event_scheduler.sv
// Two-producer event scheduler: per-input FIFOs with skid-aware ready, drop counters,
// and a round-robin arbiter feeding a single registered output slot.
module event_scheduler
  import event_sched_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int FIFO_DEPTH = 4,
  parameter  int SKID       = 2,
  localparam int VW         = calc_vw(DATA_WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [VW-1:0]     in0_event_value,
  input  logic              in0_event_valid,
  input  logic [ADDR_W-1:0] in0_event_addr,
  input  logic [VW-1:0]     in1_event_value,
  input  logic              in1_event_valid,
  input  logic [ADDR_W-1:0] in1_event_addr,
  output logic              in0_ready,
  output logic              in1_ready,
  output logic [VW-1:0]     out_event_value,
  output logic [ADDR_W-1:0] out_event_addr,
  output logic              out_event_src,
  output logic              out_event_valid,
  input  logic              out_ready,
  output logic [7:0]        drop_count0,
  output logic [7:0]        drop_count1
);

  localparam int EW = VW + ADDR_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [EW-1:0] in_data    [2];
  logic [EW-1:0] head       [2];
  logic [CW-1:0] fifo_count [2];
  logic [7:0]    drop_w     [2];
  logic [1:0]    in_valid, push, pop, full, empty, ready_w;

  arb_state_e    state_q, state_d;
  logic          prio_q;
  logic          grant_valid, grant_src, load;
  logic [VW-1:0]     value_q;
  logic [ADDR_W-1:0] addr_q;
  logic              src_q;

  assign in_data[0] = {in0_event_value, in0_event_addr};
  assign in_data[1] = {in1_event_value, in1_event_addr};
  assign in_valid   = {in1_event_valid, in0_event_valid};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_in
      logic [CW-1:0] cnt_next;
      logic          ready_q, ready_d;
      logic [7:0]    drop_q, drop_d;

      // A full FIFO still accepts when the arbiter pops it in the same cycle.
      assign push[gi] = in_valid[gi] & (~full[gi] | pop[gi]);

      event_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push[gi]),
        .pop_i   (pop[gi]),
        .data_i  (in_data[gi]),
        .data_o  (head[gi]),
        .count_o (fifo_count[gi]),
        .full_o  (full[gi]),
        .empty_o (empty[gi])
      );

      // Ready is registered from the next count so it reflects the occupancy the
      // producer will see, leaving room for SKID events still in its pipeline.
      always_comb begin
        cnt_next = fifo_count[gi] + CW'(push[gi]) - CW'(pop[gi]);
        ready_d  = (32'(cnt_next) + 32'(SKID)) < 32'(FIFO_DEPTH);
        drop_d   = drop_q;
        if (in_valid[gi] && !push[gi] && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ready_q <= 1'b0;
          drop_q  <= '0;
        end else begin
          ready_q <= ready_d;
          drop_q  <= drop_d;
        end
      end

      assign ready_w[gi] = ready_q;
      assign drop_w[gi]  = drop_q;
    end
  endgenerate

  always_comb begin
    grant_valid = ~empty[0] | ~empty[1];
    grant_src   = (!empty[0] && !empty[1]) ? prio_q : empty[0];
    load        = grant_valid && ((state_q == ST_IDLE) || out_ready);
    pop         = 2'b00;
    if (load) pop[grant_src] = 1'b1;
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load) state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = load ? ST_HOLD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Slot contents only change on load, keeping them stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      value_q <= '0;
      addr_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        {value_q, addr_q} <= head[grant_src];
        src_q             <= grant_src;
        prio_q            <= ~grant_src;
      end
    end
  end

  assign out_event_value = value_q;
  assign out_event_addr  = addr_q;
  assign out_event_src   = src_q;
  assign out_event_valid = (state_q == ST_HOLD);
  assign in0_ready       = ready_w[0];
  assign in1_ready       = ready_w[1];
  assign drop_count0     = drop_w[0];
  assign drop_count1     = drop_w[1];

endmodule

// File: tb/tb_event_scheduler.sv
// Directed bench for event_scheduler with an expected-output scoreboard checked
// on every falling edge while the output slot is valid.
module tb_event_scheduler;
  import event_sched_pkg::*;

  typedef struct {
    logic   src;
    event_t ev;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [17:0]       in0_event_value, in1_event_value;
  logic              in0_event_valid, in1_event_valid;
  logic [15:0]       in0_event_addr, in1_event_addr;
  logic              in0_ready, in1_ready;
  logic [17:0]       out_event_value;
  logic [15:0]       out_event_addr;
  logic              out_event_src;
  logic              out_event_valid;
  logic              out_ready;
  logic [7:0]        drop_count0, drop_count1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  event_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in0_event_value (in0_event_value),
    .in0_event_valid (in0_event_valid),
    .in0_event_addr  (in0_event_addr),
    .in1_event_value (in1_event_value),
    .in1_event_valid (in1_event_valid),
    .in1_event_addr  (in1_event_addr),
    .in0_ready       (in0_ready),
    .in1_ready       (in1_ready),
    .out_event_value (out_event_value),
    .out_event_addr  (out_event_addr),
    .out_event_src   (out_event_src),
    .out_event_valid (out_event_valid),
    .out_ready       (out_ready),
    .drop_count0     (drop_count0),
    .drop_count1     (drop_count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard compare at the falling edge; the head is popped only when accepted.
  task automatic monitor();
    exp_t e;
    if (rst_n && out_event_valid) begin
      if (exp_q.size() == 0) begin
        chk("stale_valid", 32'(out_event_valid), 32'd0);
      end else begin
        e = exp_q[0];
        chk("out_src",   32'(out_event_src),   32'(e.src));
        chk("out_value", 32'(out_event_value), 32'(e.ev.value));
        chk("out_addr",  32'(out_event_addr),  32'(e.ev.addr));
        $display("OUT src=%0d value=%05h addr=%04h ready=%0d",
                 out_event_src, out_event_value, out_event_addr, out_ready);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic src, input logic [17:0] v, input logic [15:0] a);
    exp_t e;
    e.src      = src;
    e.ev.value = v;
    e.ev.addr  = a;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    in0_event_valid = 1'b0; in0_event_value = '0; in0_event_addr = '0;
    in1_event_valid = 1'b0; in1_event_value = '0; in1_event_addr = '0;

    // Reset state
    repeat (3) step();
    chk("rst_in0_ready", 32'(in0_ready), 32'd0);
    chk("rst_in1_ready", 32'(in1_ready), 32'd0);
    chk("rst_out_valid", 32'(out_event_valid), 32'd0);
    chk("rst_out_value", 32'(out_event_value), 32'd0);
    chk("rst_out_addr",  32'(out_event_addr), 32'd0);
    chk("rst_out_src",   32'(out_event_src), 32'd0);
    chk("rst_drop0",     32'(drop_count0), 32'd0);
    chk("rst_drop1",     32'(drop_count1), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_in0_ready", 32'(in0_ready), 32'd1);
    chk("rel_in1_ready", 32'(in1_ready), 32'd1);

    // Single event, minimum latency
    out_ready = 1'b1;
    in0_event_valid = 1'b1; in0_event_value = 18'h00123; in0_event_addr = 16'h0042;
    expect_ev(1'b0, 18'h00123, 16'h0042);
    step();
    in0_event_valid = 1'b0;
    chk("lat_not_early", 32'(out_event_valid), 32'd0);
    step();
    chk("lat_valid", 32'(out_event_valid), 32'd1);
    chk("lat_src",   32'(out_event_src), 32'd0);
    chk("lat_value", 32'(out_event_value), 32'h00123);
    chk("lat_addr",  32'(out_event_addr), 32'h0042);
    step();

    // Simultaneous stream: in0 was granted last, so in1 leads the alternation
    for (int i = 0; i < 4; i++) begin
      in0_event_valid = 1'b1; in0_event_value = 18'h01000 + 18'(i); in0_event_addr = 16'h1000 + 16'(i);
      in1_event_valid = 1'b1; in1_event_value = 18'h02000 + 18'(i); in1_event_addr = 16'h2000 + 16'(i);
      expect_ev(1'b1, 18'h02000 + 18'(i), 16'h2000 + 16'(i));
      expect_ev(1'b0, 18'h01000 + 18'(i), 16'h1000 + 16'(i));
      step();
    end
    in0_event_valid = 1'b0; in1_event_valid = 1'b0;
    repeat (8) step();
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    chk("stream_drop0", 32'(drop_count0), 32'd0);
    chk("stream_drop1", 32'(drop_count1), 32'd0);

    // Backpressure: slot holds e0, FIFO fills with e1..e4, e5 is dropped
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in0_event_valid = 1'b1; in0_event_value = 18'h03000 + 18'(i); in0_event_addr = 16'h3000 + 16'(i);
      if (i != 5) expect_ev(1'b0, 18'h03000 + 18'(i), 16'h3000 + 16'(i));
      step();
      chk($sformatf("bp_in0_ready_%0d", i), 32'(in0_ready), (i < 2) ? 32'd1 : 32'd0);
    end
    in0_event_valid = 1'b0;
    repeat (4) step();
    chk("bp_drop0", 32'(drop_count0), 32'd1);
    chk("bp_hold_valid", 32'(out_event_valid), 32'd1);

    // Full FIFO pushed and popped in the same cycle
    out_ready = 1'b1;
    in0_event_valid = 1'b1; in0_event_value = 18'h03006; in0_event_addr = 16'h3006;
    expect_ev(1'b0, 18'h03006, 16'h3006);
    step();
    in0_event_valid = 1'b0;
    chk("full_pp_count", 32'(dut.fifo_count[0]), 32'd4);
    chk("full_pp_drop0", 32'(drop_count0), 32'd1);
    chk("full_pp_ready", 32'(in0_ready), 32'd0);
    repeat (8) step();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Drop counter saturation on in1: 1 in slot, 4 buffered, 300 dropped
    out_ready = 1'b0;
    for (int i = 0; i < 305; i++) begin
      in1_event_valid = 1'b1; in1_event_value = 18'h04000 + 18'(i); in1_event_addr = 16'h4000 + 16'(i);
      if (i < 5) expect_ev(1'b1, 18'h04000 + 18'(i), 16'h4000 + 16'(i));
      step();
    end
    in1_event_valid = 1'b0;
    chk("sat_drop1", 32'(drop_count1), 32'd255);
    chk("sat_drop0", 32'(drop_count0), 32'd1);
    out_ready = 1'b1;
    repeat (8) step();
    chk("sat_drained", 32'(exp_q.size()), 32'd0);

    // Reset while holding one event with three buffered
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in0_event_valid = 1'b1; in0_event_value = 18'h05000 + 18'(i); in0_event_addr = 16'h5000 + 16'(i);
      expect_ev(1'b0, 18'h05000 + 18'(i), 16'h5000 + 16'(i));
      step();
    end
    in0_event_valid = 1'b0;
    chk("pre_rst_hold", 32'(out_event_valid), 32'd1);
    rst_n = 1'b0;
    step();
    exp_q.delete();
    chk("mid_rst_valid", 32'(out_event_valid), 32'd0);
    chk("mid_rst_drop0", 32'(drop_count0), 32'd0);
    chk("mid_rst_drop1", 32'(drop_count1), 32'd0);
    chk("mid_rst_ready", 32'(in0_ready), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) step();
    chk("post_rst_valid", 32'(out_event_valid), 32'd0);
    chk("post_rst_ready", 32'(in0_ready), 32'd1);
    chk("post_rst_drop0", 32'(drop_count0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
